start_stop_conditioner: RTL
===========================

# start_stop_conditioner

Conditions the raw asynchronous start/stop push-button into clean, single-cycle press events for the slot-machine control FSM. It runs in the `slot_clk` domain and produces the following signals:
- `press_pulse`, consumed by the SET/RUN/STOP/WIN FSM in place of a raw synchronized level.
- A stable debounced level.
- Release and long-press events, for future features such as auto-stop and attract mode.

It contains a two-flop synchronizer, a debounce state machine and a hold-time counter.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable `slot_clk` samples required to accept a level change. Legal range ≥ 2.
- `LONG_PRESS_CYCLES`, default 64: debounced-high cycles before `long_press` fires. Must be greater than `DEBOUNCE_CYCLES`.

Ports:
- `slot_clk` input 1: block clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `btn_raw` input 1: raw button, asynchronous to `slot_clk`, active-high.
- `lockout` input 1: synchronous. While high, suppresses `press_pulse` and `long_press`.
- `press_pulse` output 1: one-cycle pulse per accepted press.
- `release_pulse` output 1: one-cycle pulse per accepted release.
- `long_press` output 1: one-cycle pulse when a press has been held for `LONG_PRESS_CYCLES`.
- `btn_level` output 1: debounced button level.
- `long_held` output 1: high from the `long_press` cycle until the accepted release.

## Operation
- **Synchronizer.**
  - `btn_raw` passes through 2 flops; the result is `btn_s`.
  - Both flops reset to 0.
- **Debounce counter.**
  - Width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - It clears on every state change.
- **Hold counter.**
  - Width is `$clog2(LONG_PRESS_CYCLES+1)` and it saturates.
  - It increments every cycle in PRESSED and freezes in DEB_RELEASE.
  - It clears on entry to IDLE.
- **States.** The FSM has five states: IDLE, DEB_PRESS, PRESSED, LONG, DEB_RELEASE.
  - **IDLE:**
    - Drives `btn_level`=0.
    - If `btn_s`=1, go to DEB_PRESS with debounce count = 1.
  - **DEB_PRESS:**
    - If `btn_s`=0, go to IDLE. No pulse.
    - Otherwise, if count == `DEBOUNCE_CYCLES`-1, go to PRESSED and assert `press_pulse`, unless `lockout` is high.
    - Otherwise, increment the count.
  - **PRESSED:**
    - Drives `btn_level`=1.
    - If `btn_s`=0, go to DEB_RELEASE with count = 1.
    - Otherwise, if hold count == `LONG_PRESS_CYCLES`-1, go to LONG and assert `long_press` (subject to `lockout`).
  - **LONG:**
    - Drives `btn_level`=1 and `long_held`=1.
    - If `btn_s`=0, go to DEB_RELEASE with count = 1.
  - **DEB_RELEASE:**
    - Drives `btn_level`=1.
    - `long_held` keeps its value.
    - If `btn_s`=1, return to PRESSED or LONG according to the registered `was_long` flag. No pulse is issued.
    - Otherwise, if count == `DEBOUNCE_CYCLES`-1, go to IDLE, assert `release_pulse`, and clear `long_held` and `was_long`.
- **Lockout.**
  - `lockout` is sampled in the same cycle as the qualifying transition.
  - A suppressed press or long-press event is dropped, never deferred.
  - The state machine advances regardless of `lockout`.
  - `release_pulse` is never suppressed.
- **Pulse exclusivity.**
  - At most one of `press_pulse`, `release_pulse` and `long_press` is high in any cycle.
  - Every `press_pulse` is followed by exactly one `release_pulse` before the next `press_pulse`.

## Timing
- **Output registration.** All outputs are registered and driven from flops, with no combinational path from `btn_raw` or `lockout`.
- **Reset values.** Every output resets to 0 and the state resets to IDLE.
- **Reset mid-operation.** Reset clears everything immediately (asynchronous). A button still held at reset release is treated as a new press.
- **Press latency.** Let edge 0 be the first edge that samples `btn_raw`=1, with `btn_raw` stable thereafter. `press_pulse` is high for the one cycle following edge `DEBOUNCE_CYCLES`+1. With the default (4), that is after edge 5.
- **Release latency.** Release is symmetric: `release_pulse` follows edge `DEBOUNCE_CYCLES`+1 after the first low sample.
- **Long-press latency.** `long_press` fires `LONG_PRESS_CYCLES` edges after the edge that entered PRESSED. The hold count does not advance during DEB_RELEASE.
- **Glitch rejection.** A glitch of up to `DEBOUNCE_CYCLES`-1 synchronized samples produces no output change.

## Structure
- **Shared package.** `btn_state_t` (5-value enum) goes into the shared `slot_pkg` package, alongside the existing FSM state type.
- **Sub-module.** `sync2` is a generic two-flop synchronizer with reset value 0. It can later replace the inline synchronizers in the top level.
- **Local logic.** The debounce and hold counters and the FSM stay in `start_stop_conditioner`.
- **Size.** Expected size is about 150–200 RTL lines.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LONG_PRESS_CYCLES`=16.
- **Clean press/release.** Raise `btn_raw` for 10 cycles, then drop it. Expect:
  - `press_pulse` once, 6 edges after the first high sample.
  - `btn_level` high.
  - `release_pulse` once, 6 edges after the first low sample.
  - No `long_press`.
- **Bounce.** Apply `btn_raw` pattern 1,1,0,1,1,1,1,… Expect exactly one `press_pulse`, timed from the last rising transition (6 edges).
- **Long press.** Hold for 30 cycles. Expect:
  - `long_press` exactly once, 16 edges after PRESSED entry.
  - `long_held`=1 until `release_pulse`.
  - Then `long_held`=0.
- **Release glitch.** While in PRESSED, drop `btn_raw` for 2 cycles. Expect no `release_pulse`, `btn_level` stays 1, and `long_press` is still delivered, delayed by the frozen cycles.
- **Lockout.** Hold `lockout`=1 through a full press. Expect no `press_pulse`, `btn_level`=1, and `release_pulse` still delivered. Lowering `lockout` while the button is held produces no late `press_pulse`.
- **Reset mid-press.** Assert `rst` in LONG. Expect all outputs 0 at once. With the button held after reset release, expect a fresh `press_pulse` 6 edges later.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared types for the slot-machine control path: main game FSM state and
// the start/stop button conditioner state.
package slot_pkg;

  typedef enum logic [1:0] {
    SLOT_SET,
    SLOT_RUN,
    SLOT_STOP,
    SLOT_WIN
  } slot_state_t;

  typedef enum logic [2:0] {
    BTN_IDLE,
    BTN_DEB_PRESS,
    BTN_PRESSED,
    BTN_LONG,
    BTN_DEB_RELEASE
  } btn_state_t;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer, flops reset to 0.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             slot_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;

  always_ff @(posedge slot_clk or posedge rst) begin
    if (rst) begin
      meta_reg <= '0;
      q        <= '0;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/start_stop_conditioner.sv
// Turns the raw start/stop button into debounced level plus single-cycle
// press, release and long-press events for the slot control FSM.
module start_stop_conditioner
  import slot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 64
) (
  input  logic slot_clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic lockout,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic btn_level,
  output logic long_held
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);

  logic          btn_s;
  btn_state_t    state;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic          was_long;

  sync2 #(.WIDTH(1)) u_sync (
    .slot_clk (slot_clk),
    .rst      (rst),
    .d        (btn_raw),
    .q        (btn_s)
  );

  // btn_level and long_held are updated on the transition edge so they
  // always agree with the state they describe.
  always_ff @(posedge slot_clk or posedge rst) begin
    if (rst) begin
      state         <= BTN_IDLE;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      was_long      <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      btn_level     <= 1'b0;
      long_held     <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      case (state)
        BTN_IDLE: begin
          btn_level <= 1'b0;
          hold_cnt  <= '0;
          if (btn_s) begin
            state   <= BTN_DEB_PRESS;
            deb_cnt <= DW'(1);
          end
        end
        BTN_DEB_PRESS: begin
          if (!btn_s) begin
            state   <= BTN_IDLE;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state       <= BTN_PRESSED;
            deb_cnt     <= '0;
            btn_level   <= 1'b1;
            press_pulse <= !lockout;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        BTN_PRESSED: begin
          if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
          if (!btn_s) begin
            state   <= BTN_DEB_RELEASE;
            deb_cnt <= DW'(1);
          end else if (hold_cnt == HOLD_LAST) begin
            state      <= BTN_LONG;
            was_long   <= 1'b1;
            long_held  <= 1'b1;
            long_press <= !lockout;
          end
        end
        BTN_LONG: begin
          if (!btn_s) begin
            state   <= BTN_DEB_RELEASE;
            deb_cnt <= DW'(1);
          end
        end
        BTN_DEB_RELEASE: begin
          // Hold count is frozen here so a release glitch only delays long_press.
          if (btn_s) begin
            state   <= was_long ? BTN_LONG : BTN_PRESSED;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state         <= BTN_IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            btn_level     <= 1'b0;
            long_held     <= 1'b0;
            was_long      <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        default: begin
          state   <= BTN_IDLE;
          deb_cnt <= '0;
        end
      endcase
    end
  end

endmodule
